// File: rtl/wb_timer_slave.sv
// wb_timer_slave: Wishbone B4 classic slave holding a RISC-V machine timer.
//   A 64-bit mtime counter advances on prescaler ticks. A 64-bit mtimecmp
//   register is compared against it to drive a level interrupt.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   wb_cyc_i/wb_stb_i  request qualifiers
//   wb_we_i            write (1) / read (0)
//   wb_adr_i           byte address; only bits [4:2] are decoded
//   wb_dat_i/wb_sel_i  write data and byte lane enables
//   wb_ack_o/wb_dat_o  registered acknowledge and read data
//   timer_irq_o        registered machine-timer interrupt (mtime >= mtimecmp)
module wb_timer_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [7:0]  DIV_RESET  = 8'd0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic                    wb_ack_o,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  output logic                    timer_irq_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned TW = 64;

  logic [TW-1:0]         r_mtime;
  logic [TW-1:0]         r_mtimecmp;
  logic                  r_en;
  logic [7:0]            r_div;
  logic [7:0]            r_pcnt;

  logic                  w_req;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_tick;
  logic [2:0]            w_off;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_ctrl;
  logic                  w_unused_adr;

  // Upper address bits belong to the interconnect's base decode.
  assign w_unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:5], wb_adr_i[1:0]};

  assign w_off  = wb_adr_i[4:2];
  assign w_req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign w_wr   = w_req & wb_we_i;
  assign w_rd   = w_req & ~wb_we_i;
  assign w_tick = r_en & (r_pcnt == r_div);
  assign w_ctrl = {16'd0, r_div, 7'd0, r_en};

  // Byte-lane merge of write data onto a current register word.
  function automatic logic [DATA_WIDTH-1:0] f_merge(
    input logic [DATA_WIDTH-1:0] i_old,
    input logic [DATA_WIDTH-1:0] i_new,
    input logic [NB-1:0]         i_sel
  );
    logic [DATA_WIDTH-1:0] v;
    v = i_old;
    for (int i = 0; i < int'(NB); i++) begin
      if (i_sel[i]) v[8*i +: 8] = i_new[8*i +: 8];
    end
    return v;
  endfunction

  // Read mux over the current register values.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      3'd0:    w_rdata = r_mtime[31:0];
      3'd1:    w_rdata = r_mtime[63:32];
      3'd2:    w_rdata = r_mtimecmp[31:0];
      3'd3:    w_rdata = r_mtimecmp[63:32];
      3'd4:    w_rdata = w_ctrl;
      default: w_rdata = '0;
    endcase
  end

  // Bus handshake and read data capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
      if (w_rd) wb_dat_o <= w_rdata;
    end
  end

  // Control register and prescaler; a ctrl write restarts the prescale phase.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en   <= 1'b1;
      r_div  <= DIV_RESET;
      r_pcnt <= 8'd0;
    end else begin
      if (w_wr && w_off == 3'd4) begin
        if (wb_sel_i[0]) r_en  <= wb_dat_i[0];
        if (wb_sel_i[1]) r_div <= wb_dat_i[15:8];
        r_pcnt <= 8'd0;
      end else if (r_en) begin
        r_pcnt <= w_tick ? 8'd0 : r_pcnt + 8'd1;
      end
    end
  end

  // mtime: a software write to either word suppresses that cycle's tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mtime <= '0;
    end else if (w_wr && w_off == 3'd0) begin
      r_mtime[31:0] <= f_merge(r_mtime[31:0], wb_dat_i, wb_sel_i);
    end else if (w_wr && w_off == 3'd1) begin
      r_mtime[63:32] <= f_merge(r_mtime[63:32], wb_dat_i, wb_sel_i);
    end else if (w_tick) begin
      r_mtime <= r_mtime + TW'(1);
    end
  end

  // mtimecmp register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mtimecmp <= '1;
    end else if (w_wr && w_off == 3'd2) begin
      r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], wb_dat_i, wb_sel_i);
    end else if (w_wr && w_off == 3'd3) begin
      r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], wb_dat_i, wb_sel_i);
    end
  end

  // Level interrupt from the current-cycle compare.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) timer_irq_o <= 1'b0;
    else       timer_irq_o <= (r_mtime >= r_mtimecmp);
  end

endmodule

// File: doc/wb_timer_slave.md
# wb_timer_slave

Wishbone B4 classic slave implementing a RISC-V machine timer: a 64-bit free-running `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register and a level timer-interrupt output. It is the responder that sits behind the CPU's data-side Wishbone master (through the bus interconnect) and answers single-beat register reads and writes. The interrupt output feeds the CPU's machine-timer interrupt input.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: Wishbone address width.
- `DATA_WIDTH`, 32: Wishbone data width. Only 32 is supported.
- `DIV_RESET`, 8'd0: reset value of the prescaler divide field.

Ports:
- `clk_i` input 1: the single clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `wb_cyc_i` input 1: bus cycle valid.
- `wb_stb_i` input 1: strobe; a request is present when both cyc and stb are high.
- `wb_ack_o` output 1: acknowledge, registered.
- `wb_adr_i` input ADDR_WIDTH: byte address. Only bits [4:2] are decoded; the interconnect does the base decode.
- `wb_dat_i` input DATA_WIDTH: write data.
- `wb_dat_o` output DATA_WIDTH: read data, registered, valid while ack is high.
- `wb_sel_i` input DATA_WIDTH/8: byte lane enables for writes.
- `wb_we_i` input 1: 1 selects write, 0 selects read.
- `timer_irq_o` output 1: machine timer interrupt, level, registered.

## Operation
Register map (word offset, from bits [4:2]):
- 0: `mtime[31:0]`
- 1: `mtime[63:32]`
- 2: `mtimecmp[31:0]`
- 3: `mtimecmp[63:32]`
- 4: `ctrl`, where bit0 is `en`, bits[15:8] are `div`, and all other bits read as 0.
- 5–7: reserved. Reads return 0, writes are ignored, and the access is still acked.

Reset values:
- `mtime` = 0
- `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF
- `en` = 1
- `div` = DIV_RESET
- prescale counter = 0
- `wb_ack_o` = 0
- `wb_dat_o` = 0
- `timer_irq_o` = 0

Counter and prescaler:
- The prescale counter is 8 bits. When `en` = 1 and the counter equals `div`, a tick occurs and the counter returns to 0. Otherwise the counter increments.
- `div` = 0 therefore ticks every cycle; `div` = N ticks every N+1 cycles.
- On a tick, `mtime` increments as a full 64-bit value, with carry from the low word into the high word. It wraps from 2^64−1 to 0.
- `en` = 0 freezes both `mtime` and the prescale counter.
- Any write to `ctrl` clears the prescale counter.

Writes:
- A write happens at the clock edge where the request is present and `wb_ack_o` = 0.
- Each byte lane i is updated only if `wb_sel_i[i]` is set.
- If a write to `mtime` (either word) and a tick fall in the same cycle, the write wins. The written word takes the merged value, the other word keeps its current value, and there is no increment that cycle.

Reads:
- `wb_dat_o` captures the register value present in the request cycle, before any tick applied at the same edge.

Interrupt:
- `timer_irq_o` is registered from the unsigned 64-bit compare `mtime >= mtimecmp` of the current register values.
- It stays high until software raises `mtimecmp` or lowers `mtime`.

## Timing
- Handshake: `wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o`.
- A request seen in cycle N gets ack in cycle N+1, high for exactly one cycle, with read data valid in that cycle.
- If stb is still high in N+2, that is treated as a new request; the next ack comes in N+3. Sustained back-to-back throughput is one access per 2 cycles.
- Dropping cyc or stb in cycle N+1 does not cancel the ack already issued. The write was already committed at the end of cycle N.
- Write latency: the new value is readable by a request issued in cycle N+1.
- Interrupt latency: `timer_irq_o` reflects the register state of the previous cycle. A `mtimecmp` write committed at the end of cycle N changes the irq at the end of cycle N+1.
- Reset asserted mid-transaction: ack, data and irq go to 0 immediately (asynchronously). The interrupted request is lost and is not acked after reset is released.

## Test plan
- Reset, then idle 10 cycles with div = 0 → reading offset 0 returns 10 (±1 for the read cycle); ack is exactly 1 cycle wide, one cycle after stb.
- Write ctrl = 32'h0000_0301 (div = 3), then read `mtime` low twice with 40 cycles between the reads → the difference is 10.
- Write `mtime` low = FFFF_FFFF and high = 0 with en = 0, then set en = 1 with div = 0 → after one tick, low reads 0 and high reads 1.
- Write `mtimecmp` high = 0 and low = 100 with `mtime` at 50 → `timer_irq_o` rises the cycle after `mtime` reaches 100; writing `mtimecmp` high = 1 drops it one cycle after the write commits.
- Write offset 2 with sel = 4'b0010 and data 32'hAABB_CCDD onto FFFF_FFFF → it reads FFFF_CCFF. Writes to offset 6 are acked and read back 0.
- Hold stb for 6 cycles on a read → acks in cycles 1, 3 and 5 only. Assert rst_i in the cycle the ack is due → ack stays 0, and all registers return to their reset values.
